// File: rtl/bypass_tracker_pkg.sv
// Shared stage indices and tracking-entry type for the decode bypass tracker.
// Data type defaults to a 32-bit GPR value.
package cpu_core_params;

  typedef logic [31:0] CpuData;

  localparam int STAGE_EXE  = 0;
  localparam int STAGE_MEM  = 1;
  localparam int STAGE_WB   = 2;
  localparam int STAGE_RF   = 3;
  localparam int NUM_STAGES = 3;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wen;
    logic       is_load;
  } bypass_entry_t;

  function automatic logic entry_hit(
    input bypass_entry_t e,
    input logic [4:0]    r
  );
    return e.valid && e.wen &&
           (e.dest == r) && (r != 5'd0);
  endfunction

endpackage

// File: rtl/bypass_port_match.sv
// One decode read port: youngest-match select and load-use stall.
// CPU_BYPASS_EN enables forwarding; otherwise any match stalls.
module bypass_port_match
  import cpu_core_params::*;
(
  input  bypass_entry_t entry [NUM_STAGES],
  input  logic [4:0]    src_reg,
  input  logic          mem_load_ok,
  output logic [0:2]    sel,
  output logic          stall
);

  logic [0:2] hit;

  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) begin
      hit[s] = entry_hit(entry[s], src_reg);
    end
  end

`ifdef CPU_BYPASS_EN
  logic unused_load;
  assign unused_load = entry[STAGE_WB].is_load;

  // Youngest stage wins; overlapping hits are expected.
  always_comb begin
    sel   = '0;
    stall = 1'b0;
    priority case (1'b1)
      hit[STAGE_EXE]: begin
        sel[STAGE_EXE] = 1'b1;
        stall = entry[STAGE_EXE].is_load;
      end
      hit[STAGE_MEM]: begin
        sel[STAGE_MEM] = 1'b1;
        stall = entry[STAGE_MEM].is_load &&
                !mem_load_ok;
      end
      hit[STAGE_WB]: begin
        sel[STAGE_WB] = 1'b1;
      end
      default: ;
    endcase
  end
`else
  logic unused_load;
  assign unused_load = ^{mem_load_ok,
                         entry[STAGE_EXE].is_load,
                         entry[STAGE_MEM].is_load,
                         entry[STAGE_WB].is_load};

  assign sel   = '0;
  assign stall = |hit;
`endif

endmodule

// File: rtl/bypass_tracker.sv
// Tracks GPR writers in EXE/MEM/WB and steers decode operand bypass.
// Build with CPU_BYPASS_EN for forwarding; default build interlocks.
module bypass_tracker
  import cpu_core_params::*;
#(
  parameter int  READ_PORTS = 2,
  parameter type DataType   = cpu_core_params::CpuData
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        id_fire,
  input  logic [4:0]  id_dest,
  input  logic        id_wen,
  input  logic        id_is_load,
  input  logic        exe_fire,
  input  logic        mem_fire,
  input  logic        wb_fire,
  input  logic        flush,
  input  logic        mem_load_ok,
  input  DataType     exe_result,
  input  DataType     mem_result,
  input  DataType     wb_result,
  input  DataType     rf_data [READ_PORTS],
  input  logic [4:0]  src_reg [READ_PORTS],
  output logic [0:2]  fwd_select [READ_PORTS],
  output DataType     fwd_inputs [READ_PORTS][4],
  output logic        stall,
  output logic [31:0] stall_count
);

  bypass_entry_t stage_q [NUM_STAGES];
  bypass_entry_t stage_d [NUM_STAGES];
  logic [READ_PORTS-1:0] port_stall;

  always_comb begin
    stage_d = stage_q;

    if (flush) begin
      stage_d[STAGE_EXE].valid = 1'b0;
    end else if (id_fire) begin
      stage_d[STAGE_EXE] = '{valid:   1'b1,
                             dest:    id_dest,
                             wen:     id_wen,
                             is_load: id_is_load};
    end else if (exe_fire) begin
      stage_d[STAGE_EXE].valid = 1'b0;
    end

    if (flush) begin
      stage_d[STAGE_MEM].valid = 1'b0;
    end else if (exe_fire) begin
      stage_d[STAGE_MEM] = stage_q[STAGE_EXE];
    end else if (mem_fire) begin
      stage_d[STAGE_MEM].valid = 1'b0;
    end

    // WB still accepts MEM during a flush.
    if (mem_fire) begin
      stage_d[STAGE_WB] = stage_q[STAGE_MEM];
    end else if (wb_fire) begin
      stage_d[STAGE_WB].valid = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    bypass_port_match u_match (
      .entry       (stage_q),
      .src_reg     (src_reg[p]),
      .mem_load_ok (mem_load_ok),
      .sel         (fwd_select[p]),
      .stall       (port_stall[p])
    );
  end

  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      fwd_inputs[p][STAGE_EXE] = exe_result;
      fwd_inputs[p][STAGE_MEM] = mem_result;
      fwd_inputs[p][STAGE_WB]  = wb_result;
      fwd_inputs[p][STAGE_RF]  = rf_data[p];
    end
  end

  assign stall = |port_stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule
